// File: rtl/mat_vec_serializer.sv
// Snapshots the normal-equation matrix (lower triangle) and vector on frame end, then streams them one word per valid/ready transfer.
// Optional build macro MATSER_FULL_SYM_EN expands the stream to the full symmetric 6x6 matrix (42 words).
module mat_vec_serializer #(
  parameter int DATA_BW = 32,
  parameter int IDX_BW  = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_frame_end,
  input  logic [21*DATA_BW-1:0]  i_mat_flat,
  input  logic [6*DATA_BW-1:0]   i_vec_flat,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [DATA_BW-1:0]     o_data,
  output logic [IDX_BW-1:0]      o_idx,
  output logic                   o_last,
  output logic                   o_busy,
  output logic                   o_overrun
);

`ifdef MATSER_FULL_SYM_EN
  localparam int N = 42;
`else
  localparam int N = 27;
`endif
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [IDX_BW-1:0]      idx_q, idx_d, idx_nxt;
  logic [DATA_BW-1:0]     data_q, data_d;
  logic                   last_q, last_d;
  logic                   overrun_q, overrun_d;
  logic [21*DATA_BW-1:0]  snap_mat_q, snap_mat_d;
  logic [6*DATA_BW-1:0]   snap_vec_q, snap_vec_d;

  // Column-major lower-triangle slot of Mat_rc, r >= c.
  function automatic int mat_slot(input int r, input int c);
    return c * 6 - (c * (c - 1)) / 2 + (r - c);
  endfunction

  function automatic logic [DATA_BW-1:0] word_sel(
    input logic [IDX_BW-1:0]     idx,
    input logic [21*DATA_BW-1:0] mat,
    input logic [6*DATA_BW-1:0]  vec
  );
    int i;
    logic [DATA_BW-1:0] w;
    i = int'(idx);
    w = '0;
`ifdef MATSER_FULL_SYM_EN
    if (i < 36) begin
      if (i / 6 >= i % 6) w = mat[mat_slot(i / 6, i % 6) * DATA_BW +: DATA_BW];
      else                w = mat[mat_slot(i % 6, i / 6) * DATA_BW +: DATA_BW];
    end else if (i < 42) begin
      w = vec[(i - 36) * DATA_BW +: DATA_BW];
    end
`else
    if (i < 21)      w = mat[i * DATA_BW +: DATA_BW];
    else if (i < 27) w = vec[(i - 21) * DATA_BW +: DATA_BW];
`endif
    return w;
  endfunction

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    last_d     = last_q;
    overrun_d  = 1'b0;
    snap_mat_d = snap_mat_q;
    snap_vec_d = snap_vec_q;
    case (state_q)
      IDLE: begin
        if (i_frame_end) begin
          // First word is loaded from the values being captured so it is valid one cycle later.
          snap_mat_d = i_mat_flat;
          snap_vec_d = i_vec_flat;
          idx_d      = '0;
          data_d     = word_sel('0, i_mat_flat, i_vec_flat);
          last_d     = (LAST_IDX == '0);
          state_d    = SEND;
        end
      end
      SEND: begin
        overrun_d = i_frame_end;
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_nxt;
            data_d = word_sel(idx_nxt, snap_mat_q, snap_vec_q);
            last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      overrun_q  <= 1'b0;
      snap_mat_q <= '0;
      snap_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
      snap_mat_q <= snap_mat_d;
      snap_vec_q <= snap_vec_d;
    end
  end

  assign o_valid   = (state_q == SEND);
  assign o_busy    = (state_q == SEND);
  assign o_data    = data_q;
  assign o_idx     = idx_q;
  assign o_last    = last_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_mat_vec_serializer.sv
// Scoreboard bench for mat_vec_serializer: expected words queued at capture, compared on each transfer.
module tb_mat_vec_serializer;
  localparam int DATA_BW = 32;
  localparam int IDX_BW  = 6;
`ifdef MATSER_FULL_SYM_EN
  localparam int N = 42;
`else
  localparam int N = 27;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  frame_end;
  logic [21*DATA_BW-1:0] mat_flat;
  logic [6*DATA_BW-1:0]  vec_flat;
  logic                  ready;
  logic                  o_valid, o_last, o_busy, o_overrun;
  logic [DATA_BW-1:0]    o_data;
  logic [IDX_BW-1:0]     o_idx;

  mat_vec_serializer #(.DATA_BW(DATA_BW), .IDX_BW(IDX_BW)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_end(frame_end),
    .i_mat_flat(mat_flat), .i_vec_flat(vec_flat), .i_ready(ready),
    .o_valid(o_valid), .o_data(o_data), .o_idx(o_idx), .o_last(o_last),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_BW-1:0] d;
    int                 idx;
    bit                 last;
  } exp_t;

  exp_t               sb[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 ov_cnt = 0;
  logic [DATA_BW-1:0] m_ref[21];
  logic [DATA_BW-1:0] v_ref[6];
  bit                 stall_pend = 0;
  logic [DATA_BW-1:0] held_d;
  logic [IDX_BW-1:0]  held_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < 21; i++) begin
      m_ref[i] = DATA_BW'(100 + i);
      mat_flat[i*DATA_BW +: DATA_BW] = m_ref[i];
    end
    for (int k = 0; k < 6; k++) begin
      v_ref[k] = DATA_BW'(200 + k);
      vec_flat[k*DATA_BW +: DATA_BW] = v_ref[k];
    end
  endtask

  task automatic push_stream();
    exp_t e;
`ifdef MATSER_FULL_SYM_EN
    int tab[6][6];
    int s = 0;
    for (int c = 0; c < 6; c++)
      for (int r = c; r < 6; r++) begin
        tab[r][c] = s;
        tab[c][r] = s;
        s++;
      end
    for (int i = 0; i < 36; i++) begin
      e.d = m_ref[tab[i/6][i%6]]; e.idx = i; e.last = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 6; k++) begin
      e.d = v_ref[k]; e.idx = 36 + k; e.last = (k == 5);
      sb.push_back(e);
    end
`else
    for (int i = 0; i < 21; i++) begin
      e.d = m_ref[i]; e.idx = i; e.last = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 6; k++) begin
      e.d = v_ref[k]; e.idx = 21 + k; e.last = (k == 5);
      sb.push_back(e);
    end
`endif
  endtask

  // Called #1 after a rising edge; pulses frame_end across the next edge.
  task automatic capture();
    frame_end = 1'b1;
    push_stream();
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    bit found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(posedge clk); #1;
      if (o_valid && int'(o_idx) == target) found = 1;
    end
    if (!found) chk("wait_idx_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(posedge clk); #1;
      if (!o_busy && sb.size() == 0) done = 1;
    end
    if (!done) chk("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_overrun) ov_cnt++;
    if (stall_pend && o_valid) begin
      chk("stall_data", 64'(o_data), 64'(held_d));
      chk("stall_idx", 64'(o_idx), 64'(held_i));
    end
    stall_pend = o_valid && !ready;
    held_d = o_data;
    held_i = o_idx;
    if (o_valid && ready) begin
      if (sb.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("word_data", 64'(o_data), 64'(e.d));
        chk("word_idx", 64'(o_idx), 64'(e.idx));
        chk("word_last", 64'(o_last), 64'(e.last));
      end
    end
  end

  initial begin
    int ov_base;
    rst = 1'b1; frame_end = 1'b0; ready = 1'b1;
    mat_flat = '0; vec_flat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_idx", 64'(o_idx), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_overrun", 64'(o_overrun), 64'd0);

    // Straight stream with first-word latency and snapshot isolation.
    @(posedge clk); #1;
    load_data();
    chk("pre_valid", 64'(o_valid), 64'd0);
    capture();
    chk("lat_valid", 64'(o_valid), 64'd1);
    chk("lat_idx", 64'(o_idx), 64'd0);
    chk("lat_data", 64'(o_data), 64'd100);
    mat_flat = '1;
    vec_flat = '1;
    wait_idle();
    chk("done_busy", 64'(o_busy), 64'd0);
    chk("done_valid", 64'(o_valid), 64'd0);

    // Backpressure pattern 1,0,0,1.
    load_data();
    capture();
    mat_flat = '1;
    begin
      bit done = 0;
      for (int k = 0; k < 400 && !done; k++) begin
        ready = (k % 4 == 0 || k % 4 == 3);
        @(posedge clk); #1;
        if (!o_busy && sb.size() == 0) done = 1;
      end
      if (!done) chk("stall_timeout", 64'd0, 64'd1);
    end
    ready = 1'b1;
    @(posedge clk); #1;

    // Overrun at idx 10 and on the last transfer, then restart.
    load_data();
    ov_base = ov_cnt;
    capture();
    wait_idx(10);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    chk("ovr_pulse1", 64'(o_overrun), 64'd1);
    chk("ovr_busy_mid", 64'(o_busy), 64'd1);
    wait_idx(N - 1);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    chk("ovr_pulse2", 64'(o_overrun), 64'd1);
    chk("ovr_idle", 64'(o_busy), 64'd0);
    capture();
    chk("restart_valid", 64'(o_valid), 64'd1);
    chk("restart_idx", 64'(o_idx), 64'd0);
    wait_idle();
    chk("ovr_count", 64'(ov_cnt - ov_base), 64'd2);

    // Reset mid-stream aborts, then a fresh stream starts at idx 0.
    load_data();
    capture();
    wait_idx(5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_idx", 64'(o_idx), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    chk("abort_last", 64'(o_last), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    chk("abort_stays_idle", 64'(o_valid), 64'd0);
    capture();
    chk("post_abort_idx", 64'(o_idx), 64'd0);
    chk("post_abort_data", 64'(o_data), 64'd100);
    wait_idle();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
